// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: program counter, IF/ID pipeline register and the
// instruction-memory program-load path.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              load_err,
  input  logic              run_en,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              imem_wdata_oe,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10
  } state_e;

  localparam logic [ADDR_W-1:0] PtrMax = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          err_d   = 1'b0;
        end else if (run_en) begin
          state_d = StRun;
        end
      end
      StLoad: begin
        if (load_valid) begin
          if (load_last) begin
            state_d = StIdle;
          end else if (ptr_q == PtrMax) begin
            // Last word still lands; pointer is left at the top rather than wrapping.
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (!run_en) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          instr_d = 32'h0;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_rdata;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_ready    = (state_q == StLoad);
  assign imem_we       = load_ready & load_valid;
  assign imem_wdata_oe = imem_we;
  assign imem_wdata    = load_data;
  assign imem_addr     = load_ready ? ptr_q : pc_q[ADDR_W+1:2];

  assign load_err   = err_q;
  assign pc         = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign state      = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed load/run scenarios plus a randomized run phase,
// checked against a cycle-level behavioural model and a reference memory image.
module tb_instruction_fetch;

  localparam int Depth = 1024;

  logic        clk;
  logic        rst_n;
  logic        load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, load_err;
  logic        run_en, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic        imem_we, imem_wdata_oe;
  logic [31:0] imem_wdata, imem_rdata;
  logic [31:0] pc, ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [1:0]  state;

  instruction_fetch #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .load_valid    (load_valid),
    .load_last     (load_last),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .load_err      (load_err),
    .run_en        (run_en),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_we       (imem_we),
    .imem_wdata    (imem_wdata),
    .imem_wdata_oe (imem_wdata_oe),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory the DUT drives, and the image the bench expects it to hold.
  logic [31:0] mem [Depth];
  logic [31:0] ref_mem [Depth];
  assign imem_rdata = mem[imem_addr];
  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

  int tests = 0;
  int fails = 0;

  // Behavioural model: 0 idle, 1 load, 2 run.
  int          m_state;
  int          m_ptr;
  bit          m_err;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_addr;
    bit          exp_we;
    exp_addr = (m_state == 1) ? 32'(m_ptr) : ((m_pc / 4) % Depth);
    exp_we   = (m_state == 1) && load_valid;
    chk("state", 32'(state), 32'(m_state));
    chk("pc", pc, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("load_ready", 32'(load_ready), 32'(m_state == 1));
    chk("imem_addr", 32'(imem_addr), exp_addr);
    chk("imem_we", 32'(imem_we), 32'(exp_we));
    chk("imem_wdata_oe", 32'(imem_wdata_oe), 32'(exp_we));
    if (exp_we) chk("imem_wdata", imem_wdata, load_data);
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_err = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
  endtask

  // Advance one clock edge: model consumes the inputs held across the edge.
  task automatic step();
    int          n_state, n_ptr;
    bit          n_err, n_valid;
    logic [31:0] n_pc, n_instr, n_pc4;
    n_state = m_state; n_ptr = m_ptr; n_err = m_err;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
    case (m_state)
      0: begin
        if (load_start) begin n_state = 1; n_ptr = 0; n_err = 0; end
        else if (run_en) n_state = 2;
      end
      1: begin
        if (load_valid) begin
          ref_mem[m_ptr] = load_data;
          if (load_last) n_state = 0;
          else if (m_ptr == Depth - 1) begin n_err = 1; n_state = 0; end
          else n_ptr = m_ptr + 1;
        end
      end
      default: begin
        if (!run_en) begin n_state = 0; n_valid = 0; end
        else if (redirect_valid) begin
          n_pc = redirect_pc & 32'hFFFF_FFFC; n_instr = 32'h0; n_valid = 0;
        end else if (!stall) begin
          n_instr = ref_mem[(m_pc / 4) % Depth];
          n_pc4   = m_pc + 32'd4;
          n_pc    = m_pc + 32'd4;
          n_valid = 1;
        end
      end
    endcase
    @(posedge clk);
    #1;
    m_state = n_state; m_ptr = n_ptr; m_err = n_err;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    check_all();
  endtask

  task automatic inputs_idle();
    load_start = 0; load_valid = 0; load_last = 0; load_data = 32'h0;
    run_en = 0; stall = 0; redirect_valid = 0; redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    inputs_idle();
    rst_n = 1'b1;
  endtask

  logic [31:0] ow [Depth + 1];
  logic [31:0] saved [3];

  initial begin
    for (int i = 0; i < Depth; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    inputs_idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Load words 0..7, then run through them.
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1; load_data = i; load_last = (i == 7);
      step();
    end
    load_valid = 0; load_last = 0;
    for (int i = 0; i < 8; i++) chk("mem_load", mem[i], 32'(i));
    run_en = 1;
    for (int i = 0; i < 6 && m_pc != 32'h10; i++) step();
    chk("pc_at_stall", pc, 32'h10);

    // Stall three cycles at pc 0x10, then resume.
    stall = 1;
    for (int i = 0; i < 3; i++) step();
    stall = 0; step();
    chk("resume_pc4", ifid_pc4, 32'h14);

    // Redirect wins over a simultaneous stall.
    redirect_valid = 1; stall = 1; redirect_pc = 32'h23; step();
    chk("redir_pc", pc, 32'h20);
    redirect_valid = 0; stall = 0; step();
    chk("redir_instr", ifid_instr, ref_mem[8]);

    // pc wrap at the top of the address space.
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; step();
    chk("wrap_addr", 32'(imem_addr), 32'd1023);
    redirect_valid = 0; step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);
    run_en = 0; step();

    // Overflow: 1025 words without load_last.
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i <= Depth; i++) begin
      ow[i] = $urandom;
      load_valid = 1; load_data = ow[i];
      step();
    end
    load_valid = 0;
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_state", 32'(state), 32'd0);
    chk("ovf_word0", mem[0], ow[0]);
    chk("ovf_word1023", mem[Depth - 1], ow[Depth - 1]);
    load_start = 1; step(); load_start = 0;
    chk("ovf_err_clr", 32'(load_err), 32'd0);
    load_valid = 1; load_last = 1; load_data = $urandom; step();
    load_valid = 0; load_last = 0;

    // Reset part-way through a 6-word load.
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i < 3; i++) begin
      saved[i] = $urandom;
      load_valid = 1; load_data = saved[i];
      step();
    end
    load_data = $urandom;
    do_reset();
    for (int i = 0; i < 3; i++) chk("rst_retained", mem[i], saved[i]);

    // Random program and random run-time control.
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1; load_data = $urandom; load_last = (i == 31);
      step();
    end
    load_valid = 0; load_last = 0;
    for (int i = 0; i < 300; i++) begin
      run_en         = ($urandom_range(0, 15) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      load_start     = ($urandom_range(0, 31) == 0);
      load_valid     = $urandom_range(0, 1) == 1;
      load_last      = ($urandom_range(0, 7) == 0);
      load_data      = $urandom;
      step();
    end
    inputs_idle();
    step();
    for (int i = 0; i < Depth; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
